// File: rtl/pwm_ctrl_pkg.sv
// Shared types and helpers for the PWM fade sequencer: FSM state encoding,
// full-scale level and step-divider calculation.
package pwm_ctrl_pkg;

  typedef enum logic [1:0] {
    MANUAL    = 2'd0,
    RAMP_UP   = 2'd1,
    HOLD      = 2'd2,
    RAMP_DOWN = 2'd3
  } state_e;

  function automatic int unsigned max_level(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned step_hz);
    return clk_hz / step_hz;
  endfunction

endpackage

// File: rtl/pwm_step_tick.sv
// Free-running step divider: one-cycle tick while the count sits at DIV-1.
module pwm_step_tick #(
  parameter int unsigned DIV = 10
) (
  input  logic clk_100MHz,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;

  // Tick is registered by looking one count ahead, so it is high exactly while r_cnt == DIV-1.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      if (r_cnt == CNT_W'(DIV - 1)) r_cnt <= '0;
      else                          r_cnt <= r_cnt + CNT_W'(1);
      r_tick <= (r_cnt == CNT_W'(DIV - 2));
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/pwm_fade_sequencer.sv
// Duty-level controller for the PWM generator: manual up/down stepping or an
// automatic breathe ramp. Define PWM_FADE_BTN_SYNC_EN to synchronise raw buttons.
module pwm_fade_sequencer
  import pwm_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned STEP_HZ    = 100,
  parameter int unsigned DUTY_W     = 2,
  parameter int unsigned HOLD_STEPS = 50
) (
  input  logic              clk_100MHz,
  input  logic              rst_n,
  input  logic              mode_breathe,
  input  logic              btn_up,
  input  logic              btn_down,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic              duty_valid,
  output logic [1:0]        state
);

  localparam int unsigned       DIV       = calc_div(CLK_HZ, STEP_HZ);
  localparam int unsigned       HOLD_W    = $clog2(HOLD_STEPS + 1);
  localparam logic [DUTY_W-1:0] MAX_LEVEL = DUTY_W'(max_level(DUTY_W));

  logic              w_tick;
  logic              w_up;
  logic              w_down;
  state_e            r_state;
  logic [DUTY_W-1:0] r_level;
  logic              r_valid;
  logic [HOLD_W-1:0] r_hold;

  pwm_step_tick #(.DIV(DIV)) u_step_tick (
    .clk_100MHz (clk_100MHz),
    .rst_n      (rst_n),
    .tick       (w_tick)
  );

`ifdef PWM_FADE_BTN_SYNC_EN
  logic [1:0] r_up_sync;
  logic [1:0] r_dn_sync;
  logic       r_up_prev;
  logic       r_dn_prev;
  logic       r_up_pulse;
  logic       r_dn_pulse;

  // 2-FF synchroniser, then a registered rising-edge pulse per button.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_up_sync  <= '0;
      r_dn_sync  <= '0;
      r_up_prev  <= 1'b0;
      r_dn_prev  <= 1'b0;
      r_up_pulse <= 1'b0;
      r_dn_pulse <= 1'b0;
    end else begin
      r_up_sync  <= {r_up_sync[0], btn_up};
      r_dn_sync  <= {r_dn_sync[0], btn_down};
      r_up_prev  <= r_up_sync[1];
      r_dn_prev  <= r_dn_sync[1];
      r_up_pulse <= r_up_sync[1] & ~r_up_prev;
      r_dn_pulse <= r_dn_sync[1] & ~r_dn_prev;
    end
  end

  assign w_up   = r_up_pulse;
  assign w_down = r_dn_pulse;
`else
  assign w_up   = btn_up;
  assign w_down = btn_down;
`endif

  // Mode FSM and level register; leaving breathe mode wins over any tick action.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MANUAL;
      r_level <= '0;
      r_valid <= 1'b0;
      r_hold  <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        MANUAL: begin
          if (w_up && !w_down && (r_level != MAX_LEVEL)) begin
            r_level <= r_level + DUTY_W'(1);
            r_valid <= 1'b1;
          end else if (w_down && !w_up && (r_level != '0)) begin
            r_level <= r_level - DUTY_W'(1);
            r_valid <= 1'b1;
          end
          if (mode_breathe && w_tick) r_state <= RAMP_UP;
        end
        default: begin
          if (!mode_breathe) begin
            r_state <= MANUAL;
          end else if (w_tick) begin
            case (r_state)
              RAMP_UP: begin
                if (r_level != MAX_LEVEL) begin
                  r_level <= r_level + DUTY_W'(1);
                  r_valid <= 1'b1;
                end else begin
                  r_state <= HOLD;
                  r_hold  <= '0;
                end
              end
              HOLD: begin
                r_hold <= r_hold + HOLD_W'(1);
                if (r_hold == HOLD_W'(HOLD_STEPS - 1)) r_state <= RAMP_DOWN;
              end
              RAMP_DOWN: begin
                if (r_level != '0) begin
                  r_level <= r_level - DUTY_W'(1);
                  r_valid <= 1'b1;
                end else begin
                  r_state <= RAMP_UP;
                end
              end
              default: r_state <= MANUAL;
            endcase
          end
        end
      endcase
    end
  end

  assign duty_cycle = r_level;
  assign duty_valid = r_valid;
  assign state      = r_state;

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Bench for pwm_fade_sequencer: cycle-by-cycle behavioural model plus
// directed literal checks and a randomized stimulus phase.
module tb_pwm_fade_sequencer;

  localparam int unsigned CLK_HZ     = 1000;
  localparam int unsigned STEP_HZ    = 100;
  localparam int unsigned DUTY_W     = 2;
  localparam int unsigned HOLD_STEPS = 2;
  localparam int DIV  = CLK_HZ / STEP_HZ;
  localparam int MAXL = (1 << DUTY_W) - 1;
  localparam int S_MANUAL = 0, S_RAMP_UP = 1, S_HOLD = 2, S_RAMP_DOWN = 3;
`ifdef PWM_FADE_BTN_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              mode_breathe = 1'b0;
  logic              btn_up = 1'b0;
  logic              btn_down = 1'b0;
  logic [DUTY_W-1:0] duty_cycle;
  logic              duty_valid;
  logic [1:0]        state;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;

  // Model state
  int m_lvl = 0, m_st = 0, m_held = 0, m_ec = 0;
  int m_valid = 0;
  bit up_h[5];
  bit dn_h[5];

  int exp_up[4]   = '{1, 2, 3, 3};
  int exp_down[4] = '{2, 1, 0, 0};
  int exp_lvls[7] = '{1, 2, 3, 2, 1, 0, 1};
  int exp_sts[4]  = '{1, 2, 3, 1};

  always #5 clk = ~clk;

  pwm_fade_sequencer #(
    .CLK_HZ(CLK_HZ), .STEP_HZ(STEP_HZ), .DUTY_W(DUTY_W), .HOLD_STEPS(HOLD_STEPS)
  ) dut (
    .clk_100MHz   (clk),
    .rst_n        (rst_n),
    .mode_breathe (mode_breathe),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .duty_cycle   (duty_cycle),
    .duty_valid   (duty_valid),
    .state        (state)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_lvl = 0; m_st = S_MANUAL; m_held = 0; m_ec = 0; m_valid = 0;
    for (int j = 0; j < 5; j++) begin up_h[j] = 1'b0; dn_h[j] = 1'b0; end
  endtask

  // One clock edge of the specified behaviour.
  task automatic m_step();
    bit tick, up, dn;
    int prev;
    tick = ((m_ec % DIV) == DIV - 1);
    m_ec++;
    for (int j = 4; j > 0; j--) begin up_h[j] = up_h[j-1]; dn_h[j] = dn_h[j-1]; end
    up_h[0] = btn_up;
    dn_h[0] = btn_down;
`ifdef PWM_FADE_BTN_SYNC_EN
    up = up_h[3] && !up_h[4];
    dn = dn_h[3] && !dn_h[4];
`else
    up = btn_up;
    dn = btn_down;
`endif
    prev = m_lvl;
    if (m_st == S_MANUAL) begin
      if (up && !dn) m_lvl = (m_lvl < MAXL) ? m_lvl + 1 : MAXL;
      else if (dn && !up) m_lvl = (m_lvl > 0) ? m_lvl - 1 : 0;
      if (mode_breathe && tick) m_st = S_RAMP_UP;
    end else if (!mode_breathe) begin
      m_st = S_MANUAL;
    end else if (tick) begin
      if (m_st == S_RAMP_UP) begin
        if (m_lvl < MAXL) m_lvl++;
        else begin m_st = S_HOLD; m_held = 0; end
      end else if (m_st == S_HOLD) begin
        m_held++;
        if (m_held == HOLD_STEPS) m_st = S_RAMP_DOWN;
      end else begin
        if (m_lvl > 0) m_lvl--;
        else m_st = S_RAMP_UP;
      end
    end
    m_valid = (m_lvl != prev) ? 1 : 0;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) m_reset();
    else        m_step();
  end

  // Per-cycle compare against the model.
  initial forever begin
    @(posedge clk);
    #1;
    if (rst_n) begin
      check("cyc_duty", int'(duty_cycle), m_lvl);
      check("cyc_valid", int'(duty_valid), m_valid);
      check("cyc_state", int'(state), m_st);
      if (duty_valid) valid_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic press(input bit u, input bit d, output int lvl, output int vld);
    @(negedge clk);
    btn_up = u; btn_down = d;
    @(posedge clk); #1;
    btn_up = 1'b0; btn_down = 1'b0;
    for (int i = 1; i < LAT; i++) begin @(posedge clk); #1; end
    lvl = int'(duty_cycle);
    vld = int'(duty_valid);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_for(input int s, input int d, input int budget, input string name);
    int n;
    bit met;
    n = 0;
    met = 1'b0;
    while (!met && n < budget) begin
      @(posedge clk); #1;
      n++;
      met = (int'(state) == s) && (int'(duty_cycle) == d);
    end
    check(name, int'(met), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mode_breathe = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int lvl, vld, v0, n;
    int last_d, last_s;
    int dq[$];
    int dt[$];
    int sq[$];

    repeat (3) @(posedge clk);
    #1;
    check("rst_duty_in_reset", int'(duty_cycle), 0);
    check("rst_state_in_reset", int'(state), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_duty", int'(duty_cycle), 0);
    check("rst_valid", int'(duty_valid), 0);
    check("rst_state", int'(state), S_MANUAL);

    // Manual saturation
    v0 = valid_cnt;
    for (int i = 0; i < 4; i++) begin
      press(1'b1, 1'b0, lvl, vld);
      check("man_up_lvl", lvl, exp_up[i]);
      check("man_up_valid", vld, (i < 3) ? 1 : 0);
    end
    check("man_up_valid_count", valid_cnt - v0, 3);
    for (int i = 0; i < 4; i++) begin
      press(1'b0, 1'b1, lvl, vld);
      check("man_down_lvl", lvl, exp_down[i]);
    end
    press(1'b1, 1'b0, lvl, vld);
    check("man_up_to_1", lvl, 1);
    v0 = valid_cnt;
    press(1'b1, 1'b1, lvl, vld);
    check("man_both_lvl", lvl, 1);
    check("man_both_no_valid", valid_cnt - v0, 0);
    press(1'b0, 1'b1, lvl, vld);
    check("man_back_to_0", lvl, 0);

    // Breathe cycle from level 0
    @(negedge clk);
    mode_breathe = 1'b1;
    last_d = int'(duty_cycle);
    last_s = int'(state);
    n = 0;
    while ((dq.size() < 7 || sq.size() < 4) && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (int'(duty_cycle) != last_d) begin
        dq.push_back(int'(duty_cycle)); dt.push_back(n); last_d = int'(duty_cycle);
      end
      if (int'(state) != last_s) begin
        sq.push_back(int'(state)); last_s = int'(state);
      end
    end
    check("breathe_timeout", int'(n < 300), 1);
    if (dq.size() >= 7 && sq.size() >= 4) begin
      for (int i = 0; i < 7; i++) check("breathe_level_seq", dq[i], exp_lvls[i]);
      for (int i = 0; i < 4; i++) check("breathe_state_seq", sq[i], exp_sts[i]);
      check("breathe_step_spacing", dt[1] - dt[0], DIV);
      check("breathe_hold_time", dt[3] - dt[2], (HOLD_STEPS + 2) * DIV);
    end

    // Abort from RAMP_DOWN at level 2
    wait_for(S_RAMP_DOWN, 2, 400, "abort_wait_timeout");
    mode_breathe = 1'b0;
    @(posedge clk); #1;
    check("abort_state", int'(state), S_MANUAL);
    check("abort_level", int'(duty_cycle), 2);
    press(1'b1, 1'b0, lvl, vld);
    check("abort_then_up", lvl, 3);

    // Buttons ignored during RAMP_UP
    do_reset();
    @(negedge clk);
    mode_breathe = 1'b1;
    wait_for(S_RAMP_UP, 1, 100, "auto_wait_timeout");
    dt.delete();
    last_d = int'(duty_cycle);
    for (int i = 0; i < 2 * DIV + 2; i++) begin
      @(negedge clk);
      btn_up = (i % 2 == 0);
      @(posedge clk); #1;
      if (int'(duty_cycle) != last_d) begin
        dt.push_back(i); last_d = int'(duty_cycle);
      end
    end
    btn_up = 1'b0;
    check("auto_btn_change_count", dt.size(), 2);
    if (dt.size() == 2) check("auto_btn_spacing", dt[1] - dt[0], DIV);
    check("auto_btn_level", int'(duty_cycle), 3);

    // Asynchronous reset in the middle of RAMP_UP at level 2
    wait_for(S_RAMP_UP, 2, 300, "midreset_wait_timeout");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_duty", int'(duty_cycle), 0);
    check("midreset_valid", int'(duty_valid), 0);
    check("midreset_state", int'(state), 0);
    mode_breathe = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

`ifdef PWM_FADE_BTN_SYNC_EN
    // Held raw button gives one step after 4 cycles
    do_reset();
    repeat (3) @(negedge clk);
    btn_up = 1'b1;
    v0 = 0; lvl = -1;
    last_d = int'(duty_cycle);
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk); #1;
      if (int'(duty_cycle) != last_d) begin
        v0++; if (lvl < 0) lvl = i; last_d = int'(duty_cycle);
      end
    end
    btn_up = 1'b0;
    check("sync_hold_steps", v0, 1);
    check("sync_latency", lvl, 4);
    check("sync_level", int'(duty_cycle), 1);
`endif

    // Randomized phase
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      btn_up   = ($urandom_range(0, 5) == 0);
      btn_down = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 149) == 0) mode_breathe = ~mode_breathe;
    end
    @(negedge clk);
    btn_up = 1'b0; btn_down = 1'b0;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_fade_sequencer.md
Name: pwm_fade_sequencer

Overview:
- Controller that drives the duty-level input of the team's PWM generator. It owns the brightness setting so the generator itself stays a pure datapath.
- Two modes:
  - Manual: up/down button pulses step the level, saturating at both ends.
  - Breathe: a timed state machine ramps the level up, holds it at full, then ramps it down, repeating for as long as breathe mode is selected.
- Sits between the board buttons/switches and the PWM generator. Runs on the 100 MHz board clock.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency in Hz.
- STEP_HZ, 100, ramp step rate in Hz. DIV = CLK_HZ/STEP_HZ, integer division; DIV >= 2 is required.
- DUTY_W, 2, duty level width. MAX_LEVEL = 2**DUTY_W - 1.
- HOLD_STEPS, 50, number of step ticks spent at MAX_LEVEL before ramping down. Must be >= 1.

Ports:
- clk_100MHz  input  1  system clock, all logic on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- mode_breathe  input  1  1 = breathe mode, 0 = manual mode. Level input, synchronous to clk_100MHz.
- btn_up  input  1  increment request, single-cycle pulse.
- btn_down  input  1  decrement request, single-cycle pulse.
- duty_cycle  output  DUTY_W  registered duty level to the PWM generator.
- duty_valid  output  1  one-cycle pulse, asserted in the same cycle duty_cycle shows a new value.
- state  output  2  current FSM state encoding, for debug and LEDs.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - duty_cycle=0, duty_valid=0, state=MANUAL.
  - Tick counter=0, hold counter=0.
  - Reset mid-ramp abandons the ramp. After rst_n rises, the block resumes in MANUAL at level 0.
- Step tick:
  - Counter runs 0..DIV-1 and wraps to 0.
  - tick=1 for exactly one cycle when the count equals DIV-1.
  - The counter free-runs in every state. It is not restarted on mode changes.
- State encoding: MANUAL=0, RAMP_UP=1, HOLD=2, RAMP_DOWN=3.
- MANUAL:
  - btn_up alone: level = min(level+1, MAX_LEVEL).
  - btn_down alone: level = max(level-1, 0).
  - btn_up and btn_down together: no change.
  - The new value appears on the cycle after the pulse (latency 1).
  - Saturation produces no change, so no duty_valid.
  - mode_breathe=1 sampled on a tick → RAMP_UP. The current level is kept as the starting point.
- RAMP_UP:
  - On each tick with level<MAX_LEVEL: level+1.
  - On a tick with level==MAX_LEVEL: go to HOLD and clear the hold counter; level unchanged.
- HOLD:
  - The hold counter increments on each tick.
  - On the tick where the counter reaches HOLD_STEPS-1: go to RAMP_DOWN.
- RAMP_DOWN:
  - On each tick with level>0: level-1.
  - On a tick with level==0: go to RAMP_UP; level unchanged.
- In RAMP_UP, HOLD and RAMP_DOWN, btn_up and btn_down are ignored.
- mode_breathe=0 in any auto state:
  - The FSM goes to MANUAL on the next clock edge, with no wait for a tick.
  - The level freezes at its current value.
  - This takes priority over any transition due on the same tick.
- duty_valid is 1 exactly when the duty_cycle register changed on the previous edge. It is never 1 when duty_cycle is unchanged.
- All arithmetic is DUTY_W bits wide. Saturation is checked before the add/subtract, so there is no wrap-around.
- The hold counter is wide enough to hold HOLD_STEPS: $clog2(HOLD_STEPS+1) bits.

Optional Feature:
- Macro: PWM_FADE_BTN_SYNC_EN.
- Defined:
  - btn_up and btn_down are treated as raw asynchronous levels.
  - Each passes through a 2-FF synchronizer, then a rising-edge detector, which produces the internal pulse.
  - Press-to-duty latency becomes 4 cycles.
  - Holding a button produces exactly one step.
- Undefined:
  - The ports are used directly as synchronous single-cycle pulses, with latency 1.
  - No synchronizer flops are built.

Decomposition:
- Package pwm_ctrl_pkg holds:
  - the state enum (MANUAL, RAMP_UP, HOLD, RAMP_DOWN, 2 bits);
  - a function max_level(width) returning 2**width-1;
  - a function calc_div(clk_hz, step_hz).
- One sub-module, pwm_step_tick: parameterised by DIV, ports clk_100MHz, rst_n, tick. The FSM and level register stay in the top module.

Test Plan (sim params: CLK_HZ=1000, STEP_HZ=100 so DIV=10, DUTY_W=2, HOLD_STEPS=2):
- Reset check: hold rst_n=0, then deassert. Expect duty_cycle=0, duty_valid=0, state=0. Assert rst_n=0 mid-RAMP_UP at level 2 → outputs clear immediately, without waiting for a clock edge.
- Manual saturation: 4 btn_up pulses → levels 1, 2, 3, 3, with duty_valid pulsed only 3 times. 4 btn_down pulses → 2, 1, 0, 0. Simultaneous up+down at level 1 → stays 1, no duty_valid.
- Breathe cycle from level 0, mode_breathe=1:
  - States RAMP_UP→HOLD→RAMP_DOWN→RAMP_UP.
  - Level sequence, one step per 10 clocks: 0, 1, 2, 3, then 2 ticks held at 3, then 2, 1, 0, then rising again.
- Breathe abort: in RAMP_DOWN at level 2, drop mode_breathe → state=MANUAL on the next edge, level stays 2. Then btn_up → 3.
- Buttons in auto mode: btn_up pulses during RAMP_UP have no effect on the level sequence.
- PWM_FADE_BTN_SYNC_EN: hold btn_up high for 50 cycles → exactly one increment, with duty_cycle changing 4 cycles after the rising edge.
